axis_skid_slice: RTL and testbench
==================================

Name: axis_skid_slice

Overview:
- Fully registered AXI-Stream pipeline stage: both the forward path (tvalid/tdata) and the backward path (tready) come from flops.
- Complements the forward-only slice, which passes the consumer's tready combinationally upstream; this block breaks that backward timing path.
- Two-entry storage (main + skid) sustains one beat per cycle with no bubbles.
- Sits between producer and consumer stages in the core pipeline; supports a synchronous flush (invalidate) for pipeline kills.

Parameters:
TDATA_WIDTH, 32, payload width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert handled externally
sif_tvalid  input  1  upstream beat valid
sif_tdata  input  TDATA_WIDTH  upstream payload
sif_tready  output  1  registered ready to upstream
mif_tvalid  output  1  registered valid to downstream
mif_tdata  output  TDATA_WIDTH  registered payload to downstream
mif_tready  input  1  downstream ready
invalidate  input  1  synchronous flush, discards all held beats
level  output  2  held-beat count: 0, 1 or 2

Behaviour:
- Reset (rst=0): state=EMPTY, mif_tvalid=0, mif_tdata=0, sif_tready=0, level=0. The skid data register is not reset.
- First rising edge with rst=1: sif_tready becomes 1.
- Handshakes:
  - Input accept: in = sif_tvalid & sif_tready.
  - Output accept: out = mif_tvalid & mif_tready.
  - Standard AXIS rules apply. Once asserted, mif_tvalid holds and mif_tdata stays stable until out or invalidate.
- States, stored in a 2-bit encoded register:
  - EMPTY: mif_tvalid=0, level=0.
  - ONE: main valid, mif_tvalid=1, level=1.
  - FULL: main and skid valid, mif_tvalid=1, level=2.
- Output mapping:
  - mif_tvalid = (state != EMPTY).
  - mif_tdata = main register.
  - sif_tready = ready_q, where ready_q <= (next_state != FULL).
- Transitions (invalidate=0):
  - EMPTY: in -> ONE, main <= sif_tdata. Otherwise stay.
  - ONE, in & out: -> ONE, main <= sif_tdata.
  - ONE, in & !out: -> FULL, skid <= sif_tdata.
  - ONE, !in & out: -> EMPTY.
  - ONE, neither: stay.
  - FULL: sif_tready=0, so no in. out -> ONE, main <= skid. Otherwise stay.
- invalidate=1 has highest priority:
  - next state=EMPTY, ready_q <= 1, level -> 0.
  - An output handshake in the same cycle counts as completed.
  - An input beat accepted in the same cycle is dropped.
  - mif_tdata holds its last value; it is don't-care while invalid.
- Latency and throughput:
  - A beat accepted at edge N appears on mif at edge N (visible in cycle N+1).
  - Sustained throughput is 1 beat/cycle with mif_tready held 1.
  - Backpressure from mif reaches sif_tready one cycle later; the skid entry absorbs the in-flight beat.
- Ordering: strict FIFO. No beat is duplicated or lost except by invalidate.
- Asserting rst mid-operation drops all beats immediately (asynchronous).
- Illegal encoding (2'b11) recovers to EMPTY.

Decomposition:
- Shared package axis_pkg holds typedef enum logic [1:0] axis_slice_state_t {AXIS_EMPTY, AXIS_ONE, AXIS_FULL}.
- Single flat module; no sub-module.
- A flat-port test wrapper binding sif/mif to axis_if instances lives with the benches, not in RTL.

Test Plan:
- Reset, then release; hold sif_tvalid=0 -> mif_tvalid=0, level=0, sif_tready=1 one edge after release.
- Stream 0x1..0x8 with mif_tready=1 -> mif emits 0x1..0x8 on consecutive cycles, first one cycle after accept; sif_tready stays 1.
- Send 0xA, 0xB back-to-back with mif_tready=0 -> level reaches 2, sif_tready drops the cycle after 0xB is accepted. Raise mif_tready -> 0xA then 0xB emitted, sif_tready returns to 1.
- In FULL holding 0xA/0xB, pulse invalidate for 1 cycle while sif_tvalid=1 with 0xC -> level=0, mif_tvalid=0 next cycle, and neither 0xA, 0xB nor 0xC ever appears on mif.
- Random sif_tvalid/mif_tready (50% each, 10k beats, incrementing data) -> scoreboard shows in-order, lossless delivery and AXIS stability holds.
- Assert rst asynchronously mid-stream (level=2) -> mif_tvalid and sif_tready go 0 without a clock edge; the first beat after release is fresh data.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: slice occupancy states.
package axis_pkg;

  typedef enum logic [1:0] {
    AXIS_EMPTY = 2'b00,
    AXIS_ONE   = 2'b01,
    AXIS_FULL  = 2'b10
  } axis_slice_state_t;

endpackage

// File: rtl/axis_skid_slice.sv
// Fully registered AXI-Stream slice: main + skid entries, registered tready,
// synchronous invalidate that discards every held beat.
//
// Handshake: a beat moves on a rising edge only when valid & ready are both 1
// on that interface; once raised, mif_tvalid/mif_tdata hold until that
// handshake (or invalidate), and sif_tready never depends on mif_tready
// within the same cycle.
module axis_skid_slice
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sif_tvalid,
  input  logic [TDATA_WIDTH-1:0] sif_tdata,
  output logic                   sif_tready,
  output logic                   mif_tvalid,
  output logic [TDATA_WIDTH-1:0] mif_tdata,
  input  logic                   mif_tready,
  input  logic                   invalidate,
  output logic [1:0]             level
);

  axis_slice_state_t      state_q, state_d;
  logic [TDATA_WIDTH-1:0] main_q, skid_q;
  logic                   ready_q;
  logic                   in_hs, out_hs;
  logic                   load_main_in, load_main_skid, load_skid;

  assign in_hs  = sif_tvalid & ready_q;
  assign out_hs = mif_tvalid & mif_tready;

  // State register, registered ready and main payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= AXIS_EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != AXIS_FULL);
      if (load_main_in)
        main_q <= sif_tdata;
      else if (load_main_skid)
        main_q <= skid_q;
    end
  end

  // Skid payload is only ever read after being written, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid)
      skid_q <= sif_tdata;
  end

  // Next-state and datapath load enables.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (invalidate) begin
      state_d = AXIS_EMPTY;
    end else begin
      case (state_q)
        AXIS_EMPTY: begin
          if (in_hs) begin
            state_d      = AXIS_ONE;
            load_main_in = 1'b1;
          end
        end
        AXIS_ONE: begin
          if (in_hs && out_hs) begin
            load_main_in = 1'b1;
          end else if (in_hs) begin
            state_d   = AXIS_FULL;
            load_skid = 1'b1;
          end else if (out_hs) begin
            state_d = AXIS_EMPTY;
          end
        end
        AXIS_FULL: begin
          if (out_hs) begin
            state_d        = AXIS_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = AXIS_EMPTY;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    mif_tvalid = 1'b0;
    level      = 2'd0;
    case (state_q)
      AXIS_ONE: begin
        mif_tvalid = 1'b1;
        level      = 2'd1;
      end
      AXIS_FULL: begin
        mif_tvalid = 1'b1;
        level      = 2'd2;
      end
      default: begin
        mif_tvalid = 1'b0;
        level      = 2'd0;
      end
    endcase
  end

  assign mif_tdata  = main_q;
  assign sif_tready = ready_q;

endmodule

// File: tb/tb_axis_skid_slice.sv
// Self-checking bench for axis_skid_slice: directed scenarios plus random
// traffic checked against a queue model of a two-entry FIFO stage.
module tb_axis_skid_slice;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sif_tvalid = 1'b0;
  logic [W-1:0] sif_tdata = '0;
  logic         sif_tready;
  logic         mif_tvalid;
  logic [W-1:0] mif_tdata;
  logic         mif_tready = 1'b0;
  logic         invalidate = 1'b0;
  logic [1:0]   level;

  axis_skid_slice #(.TDATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sif_tvalid (sif_tvalid),
    .sif_tdata  (sif_tdata),
    .sif_tready (sif_tready),
    .mif_tvalid (mif_tvalid),
    .mif_tdata  (mif_tdata),
    .mif_tready (mif_tready),
    .invalidate (invalidate),
    .level      (level)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the beats held by the stage, oldest first, plus the ready level
  // expected after the most recent edge.
  logic [W-1:0] exp_q[$];
  logic         m_ready = 1'b0;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ready = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  // At each falling edge: compare outputs with the model, then advance the
  // model using the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      check("level", {30'd0, level}, exp_q.size());
      check("mif_tvalid", {31'd0, mif_tvalid}, {31'd0, exp_q.size() != 0});
      check("sif_tready", {31'd0, sif_tready}, {31'd0, m_ready});
      if (exp_q.size() != 0)
        check("mif_tdata", mif_tdata, exp_q[0]);
      if (mif_tvalid && mif_tready && exp_q.size() != 0)
        void'(exp_q.pop_front());
      if (invalidate) begin
        exp_q.delete();
      end else if (sif_tvalid && sif_tready) begin
        if (exp_q.size() >= 2) begin
          checks++;
          errors++;
          $display("FAIL overflow accepted=%0h while holding %0d beats", sif_tdata, exp_q.size());
        end else begin
          exp_q.push_back(sif_tdata);
        end
      end
      m_ready = (exp_q.size() != 2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [W-1:0] d);
    int  n;
    bit  acc;
    n = 0;
    sif_tvalid = 1'b1;
    sif_tdata  = d;
    do begin
      @(negedge clk);
      acc = sif_tready;
      cycle();
      n++;
    end while (!acc && n < 1000);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
    end
    sif_tvalid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           sent;
    int           cyc;
    bit           acc;
    logic [W-1:0] nxt;

    // Reset state.
    #1;
    check("rst_mif_tvalid", {31'd0, mif_tvalid}, '0);
    check("rst_mif_tdata", mif_tdata, '0);
    check("rst_sif_tready", {31'd0, sif_tready}, '0);
    check("rst_level", {30'd0, level}, '0);
    idle(2);
    #1;
    model_reset();
    rst = 1'b1;
    mon_en = 1'b1;
    idle(3);

    // Streaming at full rate.
    mif_tready = 1'b1;
    for (int i = 1; i <= 8; i++) send(W'(i));
    idle(3);

    // Backpressure fills the skid entry, then drains in order.
    mif_tready = 1'b0;
    send(32'hA);
    send(32'hB);
    idle(3);
    mif_tready = 1'b1;
    idle(4);

    // Flush while FULL with a beat offered upstream.
    mif_tready = 1'b0;
    send(32'hA);
    send(32'hB);
    idle(1);
    sif_tvalid = 1'b1;
    sif_tdata  = 32'hC;
    invalidate = 1'b1;
    cycle();
    invalidate = 1'b0;
    sif_tvalid = 1'b0;
    mif_tready = 1'b1;
    idle(4);

    // Random traffic, incrementing payload.
    sent = 0;
    cyc  = 0;
    nxt  = 32'h1000;
    while (sent < 10000 && cyc < 60000) begin
      if (!sif_tvalid && $urandom_range(0, 1) == 1) begin
        sif_tvalid = 1'b1;
        sif_tdata  = nxt;
        nxt++;
      end
      mif_tready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc = sif_tvalid && sif_tready;
      cycle();
      cyc++;
      if (acc) begin
        sent++;
        sif_tvalid = 1'b0;
      end
    end
    check("random_sent", sent, 10000);
    mif_tready = 1'b1;
    idle(4);

    // Asynchronous reset with two beats held.
    mif_tready = 1'b0;
    send(32'h100);
    send(32'h101);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_mif_tvalid", {31'd0, mif_tvalid}, '0);
    check("async_sif_tready", {31'd0, sif_tready}, '0);
    check("async_level", {30'd0, level}, '0);
    idle(2);
    #1;
    rst = 1'b1;
    idle(2);
    mif_tready = 1'b1;
    send(32'h55);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
